// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg
// Shared constants and types for the decode stage: memory-type codes,
// opcode and ALU-op encodings, result-select codes, instruction field
// positions, the decoded-control struct and the decode helper.
package id_stage_pipe_pkg;

  // Memory-type field values
  localparam logic [3:0] MEM_SREG = 4'h1;
  localparam logic [3:0] MEM_DREG = 4'h2;

  // Opcodes as they appear in the instruction word
  localparam logic [7:0] EXE_AND = 8'h0C;
  localparam logic [7:0] EXE_OR  = 8'h0D;
  localparam logic [7:0] EXE_XOR = 8'h0E;
  localparam logic [7:0] EXE_NOR = 8'h0F;

  // ALU operation codes handed to EX
  localparam logic [7:0] EXE_AND_OP = 8'h24;
  localparam logic [7:0] EXE_OR_OP  = 8'h25;
  localparam logic [7:0] EXE_XOR_OP = 8'h26;
  localparam logic [7:0] EXE_NOR_OP = 8'h27;
  localparam logic [7:0] EXE_NOP_OP = 8'h00;

  // Result select
  typedef enum logic [2:0] {
    EXE_RES_NOP   = 3'b000,
    EXE_RES_LOGIC = 3'b001
  } alusel_e;

  // Instruction field positions
  localparam int MEM_HI = 63;
  localparam int MEM_LO = 60;
  localparam int OP_HI  = 59;
  localparam int OP_LO  = 52;
  localparam int WD_HI  = 51;
  localparam int WD_LO  = 47;
  localparam int RS1_HI = 46;
  localparam int RS1_LO = 42;
  localparam int RS2_HI = 41;
  localparam int RS2_LO = 37;
  localparam int IMM_HI = 41;
  localparam int IMM_LO = 10;

  // Decoded control for one instruction
  typedef struct packed {
    logic [7:0] aluop;
    alusel_e    alusel;
    logic       wreg;
    logic       rd1_en;
    logic       rd2_en;
    logic       use_imm;
    logic       illegal;
  } id_ctrl_t;

  // Anything that is not a logic op in SREG/DREG form decodes to a NOP
  // with no register reads and is flagged illegal.
  function automatic id_ctrl_t decode_ctrl(input logic [3:0] mem, input logic [7:0] op);
    id_ctrl_t c;
    logic     op_ok;
    c.aluop   = EXE_NOP_OP;
    c.alusel  = EXE_RES_NOP;
    c.wreg    = 1'b0;
    c.rd1_en  = 1'b0;
    c.rd2_en  = 1'b0;
    c.use_imm = 1'b0;
    c.illegal = 1'b1;
    op_ok     = 1'b1;
    case (op)
      EXE_AND: c.aluop = EXE_AND_OP;
      EXE_OR:  c.aluop = EXE_OR_OP;
      EXE_XOR: c.aluop = EXE_XOR_OP;
      EXE_NOR: c.aluop = EXE_NOR_OP;
      default: op_ok = 1'b0;
    endcase
    if (op_ok && (mem == MEM_SREG || mem == MEM_DREG)) begin
      c.alusel  = EXE_RES_LOGIC;
      c.wreg    = 1'b1;
      c.rd1_en  = 1'b1;
      c.rd2_en  = (mem == MEM_DREG);
      c.use_imm = (mem == MEM_SREG);
      c.illegal = 1'b0;
    end else begin
      c.aluop = EXE_NOP_OP;
    end
    return c;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux
// Operand source select for one register read port.
// Ports:
//   addr, rd_en         - source register address and read enable
//   rf_data             - regfile read data for addr
//   ex_wreg/ex_wd/ex_wdata    - EX-stage result bypass
//   mem_wreg/mem_wd/mem_wdata - MEM-stage result bypass
//   alt                 - value used when the port is not read
//   operand             - selected operand
module id_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] alt,
  output logic [DATA_W-1:0] operand
);
  import id_stage_pipe_pkg::*;

  // r0 is hard zero and must never pick up a bypassed value; EX is the
  // younger result, so it wins over MEM.
  always_comb begin
    operand = alt;
    if (rd_en) begin
      if (addr == '0)
        operand = '0;
      else if (ex_wreg && (ex_wd == addr))
        operand = ex_wdata;
      else if (mem_wreg && (mem_wd == addr))
        operand = mem_wdata;
      else
        operand = rf_data;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// Decode stage for the 64-bit instruction format with a registered ID/EX
// pipeline register. Decodes, reads and forwards operands, detects
// load-use hazards and inserts a single bubble toward EX.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   valid_i, ready_o         - handshake with the IF/ID register
//   pc_i, inst_i             - incoming instruction
//   reg{1,2}_read_o/addr_o   - regfile read ports
//   reg{1,2}_data_i          - regfile read data (same cycle)
//   ex_* / mem_*             - bypass and load information from EX and MEM
//   ex_ready_i, flush_i      - EX back-pressure, pipeline kill
//   valid_o ... wreg_o       - ID/EX register contents
//   stall_req_o              - load-use stall indicator
// Build option: define ID_ILLEGAL_EXC_EN to add the registered illegal_o
// output flagging accepted instructions that failed to decode.
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int IMM_SEXT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       pc_i,
  input  logic [63:0]       inst_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              ex_ready_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic              stall_req_o
`ifdef ID_ILLEGAL_EXC_EN
  ,
  output logic              illegal_o
`endif
);
  import id_stage_pipe_pkg::*;

  id_ctrl_t          ctrl;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] wd_addr;
  logic [31:0]       imm_raw;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [DATA_W-1:0] alt2;
  logic              load_use;
  logic              advance;
  logic              unused_bits;

  assign ctrl = decode_ctrl(inst_i[MEM_HI:MEM_LO], inst_i[OP_HI:OP_LO]);

  // Register fields stay 5 bits wide in the encoding; wider address
  // buses are zero-padded by the cast.
  assign rs1_addr = REG_AW'(inst_i[RS1_HI:RS1_LO]);
  assign rs2_addr = REG_AW'(inst_i[RS2_HI:RS2_LO]);
  assign wd_addr  = REG_AW'(inst_i[WD_HI:WD_LO]);
  assign imm_raw  = inst_i[IMM_HI:IMM_LO];

  generate
    if (DATA_W > 32) begin : g_imm_wide
      assign imm_ext = (IMM_SEXT != 0) ? {{(DATA_W-32){imm_raw[31]}}, imm_raw}
                                       : {{(DATA_W-32){1'b0}}, imm_raw};
    end else begin : g_imm_narrow
      assign imm_ext = imm_raw[DATA_W-1:0];
    end
  endgenerate

  // Low instruction bits carry no field, and narrow datapaths drop the
  // top of the immediate.
  assign unused_bits = ^{inst_i[IMM_LO-1:0], imm_raw};

  assign reg1_read_o = ctrl.rd1_en;
  assign reg2_read_o = ctrl.rd2_en;
  assign reg1_addr_o = rs1_addr;
  assign reg2_addr_o = rs2_addr;

  assign alt2 = ctrl.use_imm ? imm_ext : '0;

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .addr      (rs1_addr),
    .rd_en     (ctrl.rd1_en),
    .rf_data   (reg1_data_i),
    .ex_wreg   (ex_wreg_i),
    .ex_wd     (ex_wd_i),
    .ex_wdata  (ex_wdata_i),
    .mem_wreg  (mem_wreg_i),
    .mem_wd    (mem_wd_i),
    .mem_wdata (mem_wdata_i),
    .alt       ('0),
    .operand   (operand1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
    .addr      (rs2_addr),
    .rd_en     (ctrl.rd2_en),
    .rf_data   (reg2_data_i),
    .ex_wreg   (ex_wreg_i),
    .ex_wd     (ex_wd_i),
    .ex_wdata  (ex_wdata_i),
    .mem_wreg  (mem_wreg_i),
    .mem_wd    (mem_wd_i),
    .mem_wdata (mem_wdata_i),
    .alt       (alt2),
    .operand   (operand2)
  );

  // A load in EX cannot forward its data yet; one bubble lets it reach
  // MEM, from where the normal MEM bypass supplies the value.
  assign load_use = valid_i && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                    ((ctrl.rd1_en && (ex_wd_i == rs1_addr)) ||
                     (ctrl.rd2_en && (ex_wd_i == rs2_addr)));

  assign stall_req_o = load_use;
  assign advance     = !valid_o || ex_ready_i;
  assign ready_o     = advance && !load_use && !flush_i;

  // wreg_o is qualified with valid_i so a write enable never travels
  // with an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o  <= 1'b0;
      pc_o     <= '0;
      aluop_o  <= EXE_NOP_OP;
      alusel_o <= EXE_RES_NOP;
      reg1_o   <= '0;
      reg2_o   <= '0;
      wd_o     <= '0;
      wreg_o   <= 1'b0;
`ifdef ID_ILLEGAL_EXC_EN
      illegal_o <= 1'b0;
`endif
    end else if (flush_i) begin
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
`ifdef ID_ILLEGAL_EXC_EN
      illegal_o <= 1'b0;
`endif
    end else if (advance && load_use) begin
      valid_o  <= 1'b0;
      wreg_o   <= 1'b0;
      aluop_o  <= EXE_NOP_OP;
      alusel_o <= EXE_RES_NOP;
`ifdef ID_ILLEGAL_EXC_EN
      illegal_o <= 1'b0;
`endif
    end else if (advance) begin
      valid_o  <= valid_i;
      pc_o     <= pc_i;
      aluop_o  <= ctrl.aluop;
      alusel_o <= ctrl.alusel;
      reg1_o   <= operand1;
      reg2_o   <= operand2;
      wd_o     <= wd_addr;
      wreg_o   <= valid_i && ctrl.wreg;
`ifdef ID_ILLEGAL_EXC_EN
      illegal_o <= valid_i && ctrl.illegal;
`endif
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe
// Directed and randomized bench for id_stage_pipe (default parameters).
// Define ID_ILLEGAL_EXC_EN to also cover illegal_o.
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_i, ready_o;
  logic [31:0] pc_i;
  logic [63:0] inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        ex_ready_i, flush_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o, stall_req_o;
`ifdef ID_ILLEGAL_EXC_EN
  logic        illegal_o;
`endif

  id_stage_pipe #(.DATA_W(32), .REG_AW(5), .IMM_SEXT(0)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i),
    .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .valid_o(valid_o), .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .stall_req_o(stall_req_o)
`ifdef ID_ILLEGAL_EXC_EN
    , .illegal_o(illegal_o)
`endif
  );

  logic [31:0] rf [32];
  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  int total = 0;
  int bad   = 0;

  // Reference state of the ID/EX register
  logic        m_valid, m_wreg, m_chk;
  logic [31:0] m_pc, m_r1, m_r2;
  logic [7:0]  m_aluop;
  logic [2:0]  m_alusel;
  logic [4:0]  m_wd;
  logic        n_valid, n_wreg, n_chk;
  logic [31:0] n_pc, n_r1, n_r2;
  logic [7:0]  n_aluop;
  logic [2:0]  n_alusel;
  logic [4:0]  n_wd;
`ifdef ID_ILLEGAL_EXC_EN
  logic        m_ill, n_ill;
`endif
  logic        e_ready, e_stall, e_rd1, e_rd2;
  logic [4:0]  e_a1, e_a2;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] mk_sreg(input logic [7:0] op, input logic [4:0] wd,
                                          input logic [4:0] rs1, input logic [31:0] imm);
    return {MEM_SREG, op, wd, rs1, imm, 10'b0};
  endfunction

  function automatic logic [63:0] mk_dreg(input logic [7:0] op, input logic [4:0] wd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
    return {MEM_DREG, op, wd, rs1, rs2, 37'b0};
  endfunction

  function automatic logic [7:0] pick_op(input int k);
    case (k)
      0: return EXE_AND;
      1: return EXE_OR;
      2: return EXE_XOR;
      3: return EXE_NOR;
      default: return 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] alu_code(input logic [7:0] op);
    case (op)
      EXE_AND: return EXE_AND_OP;
      EXE_OR:  return EXE_OR_OP;
      EXE_XOR: return EXE_XOR_OP;
      EXE_NOR: return EXE_NOR_OP;
      default: return EXE_NOP_OP;
    endcase
  endfunction

  // Value a source register should read as this cycle
  function automatic logic [31:0] fetch_src(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return rf[a];
  endfunction

  task automatic modelStep();
    logic [3:0]  mem;
    logic [7:0]  op;
    logic [4:0]  wd, rs1, rs2;
    logic [31:0] imm;
    logic        sreg, dreg, legal, rd1, rd2, hit, lu, adv;
    mem  = inst_i[63:60];
    op   = inst_i[59:52];
    wd   = inst_i[51:47];
    rs1  = inst_i[46:42];
    rs2  = inst_i[41:37];
    imm  = inst_i[41:10];
    sreg  = (mem == MEM_SREG);
    dreg  = (mem == MEM_DREG);
    legal = (sreg || dreg) && (alu_code(op) != EXE_NOP_OP);
    rd1   = legal;
    rd2   = legal && dreg;
    hit   = (rd1 && ex_wd_i == rs1) || (rd2 && ex_wd_i == rs2);
    lu    = valid_i && ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) && hit;
    adv   = !m_valid || ex_ready_i;
    e_ready = adv && !lu && !flush_i;
    e_stall = lu;
    e_rd1 = rd1;
    e_rd2 = rd2;
    e_a1  = rs1;
    e_a2  = rs2;
    n_valid = m_valid; n_wreg = m_wreg; n_chk = m_chk; n_pc = m_pc;
    n_r1 = m_r1; n_r2 = m_r2; n_aluop = m_aluop; n_alusel = m_alusel; n_wd = m_wd;
`ifdef ID_ILLEGAL_EXC_EN
    n_ill = m_ill;
`endif
    if (rst) begin
      n_valid = 0; n_wreg = 0; n_chk = 1; n_pc = 0; n_r1 = 0; n_r2 = 0;
      n_aluop = EXE_NOP_OP; n_alusel = EXE_RES_NOP; n_wd = 0;
`ifdef ID_ILLEGAL_EXC_EN
      n_ill = 0;
`endif
    end else if (flush_i) begin
      n_valid = 0; n_wreg = 0;
`ifdef ID_ILLEGAL_EXC_EN
      n_ill = 0;
`endif
    end else if (adv && lu) begin
      n_valid = 0; n_wreg = 0; n_aluop = EXE_NOP_OP; n_chk = 0;
`ifdef ID_ILLEGAL_EXC_EN
      n_ill = 0;
`endif
    end else if (adv) begin
      n_valid  = valid_i;
      n_pc     = pc_i;
      n_aluop  = legal ? alu_code(op) : EXE_NOP_OP;
      n_alusel = legal ? EXE_RES_LOGIC : EXE_RES_NOP;
      n_r1     = rd1 ? fetch_src(rs1) : 32'd0;
      n_r2     = rd2 ? fetch_src(rs2) : ((legal && sreg) ? imm : 32'd0);
      n_wd     = wd;
      n_wreg   = valid_i && legal;
      n_chk    = 1;
`ifdef ID_ILLEGAL_EXC_EN
      n_ill = valid_i && !legal;
`endif
    end
  endtask

  task automatic checkRegs();
    checkOutput("valid_o", valid_o, m_valid);
    checkOutput("wreg_o", wreg_o, m_wreg);
    checkOutput("aluop_o", aluop_o, m_aluop);
    if (m_chk) begin
      checkOutput("pc_o", pc_o, m_pc);
      checkOutput("alusel_o", alusel_o, m_alusel);
      checkOutput("reg1_o", reg1_o, m_r1);
      checkOutput("reg2_o", reg2_o, m_r2);
      checkOutput("wd_o", wd_o, m_wd);
    end
`ifdef ID_ILLEGAL_EXC_EN
    checkOutput("illegal_o", illegal_o, m_ill);
`endif
  endtask

  // One clock: inputs are already set just after a negedge.
  task automatic applyStimulus();
    modelStep();
    #1;
    if (!rst) begin
      checkOutput("ready_o", ready_o, e_ready);
      checkOutput("stall_req_o", stall_req_o, e_stall);
      checkOutput("reg1_read_o", reg1_read_o, e_rd1);
      checkOutput("reg2_read_o", reg2_read_o, e_rd2);
      if (e_rd1) checkOutput("reg1_addr_o", reg1_addr_o, e_a1);
      if (e_rd2) checkOutput("reg2_addr_o", reg2_addr_o, e_a2);
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_wreg = n_wreg; m_chk = n_chk; m_pc = n_pc; m_r1 = n_r1;
    m_r2 = n_r2; m_aluop = n_aluop; m_alusel = n_alusel; m_wd = n_wd;
`ifdef ID_ILLEGAL_EXC_EN
    m_ill = n_ill;
`endif
    checkRegs();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; valid_i = 0; flush_i = 0; ex_ready_i = 1;
    ex_wreg_i = 0; ex_is_load_i = 0; ex_wd_i = 0; ex_wdata_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
    pc_i = 0; inst_i = 0;
  endtask

  initial begin
    m_valid = 0; m_wreg = 0; m_chk = 0; m_pc = 0; m_r1 = 0; m_r2 = 0;
    m_aluop = 0; m_alusel = 0; m_wd = 0;
`ifdef ID_ILLEGAL_EXC_EN
    m_ill = 0;
`endif
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'h0000_00F0;
    idle();
    @(negedge clk);

    // Reset
    rst = 1;
    applyStimulus();
    checkOutput("rst_valid", valid_o, 1'b0);
    checkOutput("rst_aluop", aluop_o, EXE_NOP_OP);
    checkOutput("rst_reg1", reg1_o, 32'd0);
    rst = 0;

    // SREG OR with immediate
    valid_i = 1; pc_i = 32'h100; inst_i = mk_sreg(EXE_OR, 5'd2, 5'd1, 32'h0F0F);
    applyStimulus();
    checkOutput("sreg_valid", valid_o, 1'b1);
    checkOutput("sreg_aluop", aluop_o, EXE_OR_OP);
    checkOutput("sreg_reg1", reg1_o, 32'hF0);
    checkOutput("sreg_reg2", reg2_o, 32'h0F0F);
    checkOutput("sreg_wreg", wreg_o, 1'b1);

    // Forwarding priority
    pc_i = 32'h104; inst_i = mk_dreg(EXE_AND, 5'd6, 5'd3, 5'd7);
    ex_wreg_i = 1; ex_wd_i = 5'd3; ex_wdata_i = 32'hAAAA;
    mem_wreg_i = 1; mem_wd_i = 5'd3; mem_wdata_i = 32'h5555;
    applyStimulus();
    checkOutput("fwd_ex", reg1_o, 32'hAAAA);
    ex_wreg_i = 0;
    applyStimulus();
    checkOutput("fwd_mem", reg1_o, 32'h5555);
    inst_i = mk_dreg(EXE_AND, 5'd6, 5'd0, 5'd7);
    mem_wd_i = 5'd0;
    applyStimulus();
    checkOutput("fwd_r0", reg1_o, 32'd0);

    // Load-use: one bubble, then MEM supplies the loaded value
    idle();
    valid_i = 1; pc_i = 32'h110; inst_i = mk_dreg(EXE_XOR, 5'd8, 5'd4, 5'd5);
    ex_wreg_i = 1; ex_is_load_i = 1; ex_wd_i = 5'd4; ex_wdata_i = 32'hBAD0;
    #1;
    checkOutput("lu_stall", stall_req_o, 1'b1);
    checkOutput("lu_ready", ready_o, 1'b0);
    applyStimulus();
    checkOutput("lu_bubble", valid_o, 1'b0);
    ex_wreg_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 32'h1234;
    applyStimulus();
    checkOutput("lu_issue", valid_o, 1'b1);
    checkOutput("lu_reg1", reg1_o, 32'h1234);

    // EX back-pressure
    idle();
    valid_i = 1; pc_i = 32'h120; inst_i = mk_sreg(EXE_NOR, 5'd9, 5'd2, 32'h33);
    applyStimulus();
    pc_i = 32'h124; inst_i = mk_sreg(EXE_AND, 5'd10, 5'd2, 32'h44);
    ex_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("bp_ready", ready_o, 1'b0);
      applyStimulus();
      checkOutput("bp_hold_pc", pc_o, 32'h120);
    end
    ex_ready_i = 1;
    applyStimulus();
    checkOutput("bp_release_pc", pc_o, 32'h124);

    // Flush beats a concurrent load-use stall
    flush_i = 1; valid_i = 1; inst_i = mk_dreg(EXE_OR, 5'd11, 5'd4, 5'd4);
    ex_wreg_i = 1; ex_is_load_i = 1; ex_wd_i = 5'd4;
    applyStimulus();
    checkOutput("flush_valid", valid_o, 1'b0);
    checkOutput("flush_wreg", wreg_o, 1'b0);

    // Reset in the middle of traffic
    idle();
    valid_i = 1; pc_i = 32'h130; inst_i = mk_sreg(EXE_XOR, 5'd12, 5'd1, 32'h77);
    applyStimulus();
    rst = 1;
    applyStimulus();
    checkOutput("midrst_valid", valid_o, 1'b0);
    checkOutput("midrst_pc", pc_o, 32'd0);
    checkOutput("midrst_reg2", reg2_o, 32'd0);
    checkOutput("midrst_wreg", wreg_o, 1'b0);
    rst = 0;

    // Invalid opcode still takes a slot
    valid_i = 1; pc_i = 32'h140; inst_i = {MEM_SREG, 8'hFF, 52'h0_1234_5678_9ABC};
    applyStimulus();
    checkOutput("inv_valid", valid_o, 1'b1);
    checkOutput("inv_aluop", aluop_o, EXE_NOP_OP);
    checkOutput("inv_wreg", wreg_o, 1'b0);
`ifdef ID_ILLEGAL_EXC_EN
    checkOutput("inv_illegal", illegal_o, 1'b1);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      flush_i      = ($urandom_range(0, 19) == 0);
      valid_i      = ($urandom_range(0, 3) != 0);
      ex_ready_i   = ($urandom_range(0, 3) != 0);
      pc_i         = $urandom;
      ex_wreg_i    = $urandom_range(0, 1);
      ex_is_load_i = $urandom_range(0, 1);
      ex_wd_i      = 5'($urandom_range(0, 7));
      ex_wdata_i   = $urandom;
      mem_wreg_i   = $urandom_range(0, 1);
      mem_wd_i     = 5'($urandom_range(0, 7));
      mem_wdata_i  = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: inst_i = mk_sreg(pick_op($urandom_range(0, 4)), 5'($urandom_range(0, 7)),
                                  5'($urandom_range(0, 7)), $urandom);
        3, 4:    inst_i = mk_dreg(pick_op($urandom_range(0, 4)), 5'($urandom_range(0, 7)),
                                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        default: inst_i = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(1, 31)] = $urandom;
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the 64-bit instruction format, with a registered ID/EX pipeline register.
- Decodes mem-type and opcode fields, reads operands, and forwards results from EX and MEM.
- Detects load-use hazards and stalls IF with a valid/ready handshake, inserting a bubble toward EX.
- Sits between the IF/ID register and the ex stage; drives the regfile read ports.

Parameters:
- DATA_W, 32: register/operand width.
- REG_AW, 5: register address width. Field slices stay at fixed positions; upper bits are zero-padded when REG_AW > 5.
- IMM_SEXT, 0: 1 sign-extends imm field inst[41:10] to DATA_W; 0 zero-extends it. Extra upper bits are truncated when DATA_W < 32.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  instruction from IF is valid.
- ready_o  out  1  stage accepts instruction (combinational).
- pc_i  in  32  instruction address.
- inst_i  in  64  instruction word.
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational).
- reg1_addr_o, reg2_addr_o  out  REG_AW  regfile read addresses (combinational).
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data (same cycle).
- ex_wreg_i, ex_is_load_i  in  1  EX-stage write enable; EX instruction is a load.
- ex_wd_i  in  REG_AW  EX destination register.
- ex_wdata_i  in  DATA_W  EX result.
- mem_wreg_i  in  1  MEM-stage write enable.
- mem_wd_i  in  REG_AW  MEM destination register.
- mem_wdata_i  in  DATA_W  MEM result.
- ex_ready_i  in  1  EX accepts the ID/EX register contents.
- flush_i  in  1  kill the instruction in ID and the one in the ID/EX register.
- valid_o  out  1  ID/EX register holds a valid instruction.
- pc_o  out  32  registered PC.
- aluop_o  out  8  registered ALU op.
- alusel_o  out  3  registered result select.
- reg1_o, reg2_o  out  DATA_W  registered operands.
- wd_o  out  REG_AW  registered destination.
- wreg_o  out  1  registered write enable.
- stall_req_o  out  1  load-use stall indicator to the controller.

Behaviour:
- **Field map:**
  - mem=inst[63:60], op=inst[59:52], wd=inst[51:47], rs1=inst[46:42], rs2=inst[41:37], imm=inst[41:10].
- **Decode (combinational):**
  - mem=MEM_SREG with op in {EXE_AND, EXE_OR, EXE_XOR, EXE_NOR}: read rs1 only; operand2 = extended imm; wreg=1; alusel=EXE_RES_LOGIC.
  - mem=MEM_DREG with the same ops: read rs1 and rs2; wreg=1.
  - Any other mem/op: instruction invalid. Decodes to NOP (aluop=EXE_NOP_OP, alusel=EXE_RES_NOP, wreg=0), both read enables 0, still consumes a slot.
- **Operand select, per source with read enable set (priority order):**
  1. Address 0: operand is 0 (never forwarded).
  2. ex_wreg_i && ex_wd_i==addr: ex_wdata_i.
  3. mem_wreg_i && mem_wd_i==addr: mem_wdata_i.
  4. Otherwise: regfile data.
  - Source with read disabled: operand1 = 0; operand2 = imm for SREG, else 0.
- **Hazard:**
  - load_use = valid_i && ex_is_load_i && ex_wreg_i && ex_wd_i≠0 && ex_wd_i matches any read-enabled source.
  - stall_req_o = load_use.
- **Output register update:** advance = !valid_o || ex_ready_i. ready_o = advance && !load_use && !flush_i.
- **ID/EX register, every clk edge:**
  - rst: valid_o=0, pc_o=0, aluop_o=EXE_NOP_OP, alusel_o=EXE_RES_NOP, reg1_o=reg2_o=0, wd_o=0, wreg_o=0.
  - else flush_i: valid_o=0, wreg_o=0. Flush beats stall and handshake.
  - else advance && load_use: bubble inserted (valid_o=0, wreg_o=0, aluop NOP); IF holds its instruction.
  - else advance: load decoded fields; valid_o = valid_i.
  - else (EX back-pressure): hold all outputs.
- **Timing:**
  - Latency is 1 cycle from acceptance to valid_o.
  - Throughput is 1 instruction/cycle when there is no hazard.
  - A load-use stall costs exactly 1 bubble, because the load moves to MEM and the operand comes from MEM forwarding.
- **Invariant:** wreg_o=0 whenever valid_o=0.
- **Reset mid-operation:** the pending instruction is discarded; no partial state survives.

Optional Feature:
- Macro: ID_ILLEGAL_EXC_EN.
- Defined: adds output port illegal_o (1 bit, registered, reset 0). It is set alongside valid_o when an accepted instruction is invalid, and cleared on flush and on bubble insertion.
- Undefined: the port is absent and invalid instructions silently become NOPs.

Decomposition:
- Shared package holds:
  - MEM_SREG, MEM_DREG.
  - EXE_AND/OR/XOR/NOR opcodes and their *_OP ALU codes, EXE_NOP_OP.
  - EXE_RES_LOGIC, EXE_RES_NOP.
  - Field bit positions.
  - A decoded-control struct typedef: aluop, alusel, wreg, rd1_en, rd2_en, use_imm, illegal.
- One sub-module, id_fwd_mux, instantiated twice: (addr, rd_en, rf_data, ex/mem fwd inputs, alt) to operand.

Test Plan:
- **SREG OR:** rs1=r1 (regfile 0x0000_00F0), imm=0x0F0F → next cycle valid_o=1, aluop=EXE_OR_OP, reg1_o=0xF0, reg2_o=0x0F0F, wreg_o=1.
- **Forward priority:** DREG rs1=r3; ex (wd=3, 0xAAAA) and mem (wd=3, 0x5555) both valid → reg1_o=0xAAAA. Drop ex → reg1_o=0x5555. Use rs1=r0 → reg1_o=0.
- **Load-use:** ex_is_load_i=1, ex_wd_i=4, ID instruction reads r4 → stall_req_o=1, ready_o=0, next valid_o=0. Following cycle (load in MEM, mem_wdata=0x1234) → instruction issues with reg1_o=0x1234.
- **Back-pressure:** ex_ready_i=0 for 3 cycles while valid_o=1 → outputs stable, ready_o=0. Release → next instruction loads the cycle after.
- **Flush:** flush_i concurrent with valid_i and load_use → valid_o=0, wreg_o=0 next cycle. rst asserted mid-stream → all outputs at reset values one edge later.
- **Invalid op (mem=MEM_SREG, op=0xFF):** valid_o=1, aluop=EXE_NOP_OP, wreg_o=0. With ID_ILLEGAL_EXC_EN defined, illegal_o=1.
